mfcc_frame_sequencer: RTL

MFCC_FRAME_SEQUENCER -- requirements
Module: mfcc_frame_sequencer

---
 rtl/mfcc_pkg.sv | 22 ++
 rtl/mfcc_frame_sequencer_if.sv | 33 +++
 rtl/mfcc_frame_sequencer_watchdog.sv | 32 +++
 rtl/mfcc_frame_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC frame sequencer.
// State encoding, watchdog default and overrun counter limits.
package mfcc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_WIN  = 3'd1,
    S_HAMMING   = 3'd2,
    S_WAIT_SINK = 3'd3,
    S_FFT       = 3'd4,
    S_MOVE      = 3'd5
  } seq_state_t;

  localparam int TIMEOUT_DEF = 4096;
  localparam int OVR_W       = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = '1;

  function automatic logic in_stage(input seq_state_t s);
    return (s == S_HAMMING) || (s == S_FFT);
  endfunction

endpackage

// File: rtl/mfcc_frame_sequencer_if.sv
// Stage handshake bundle between the sequencer and the
// window buffer, Hamming, FFT and power-spectrum sink.
interface mfcc_frame_sequencer_if;

  logic window_ready_i;
  logic hamming_start_o;
  logic hamming_done_i;
  logic sink_ready_i;
  logic fft_start_o;
  logic fft_done_i;
  logic start_move_o;

  modport master (
    input  window_ready_i,
    input  hamming_done_i,
    input  sink_ready_i,
    input  fft_done_i,
    output hamming_start_o,
    output fft_start_o,
    output start_move_o
  );

  modport slave (
    output window_ready_i,
    output hamming_done_i,
    output sink_ready_i,
    output fft_done_i,
    input  hamming_start_o,
    input  fft_start_o,
    input  start_move_o
  );

endinterface

// File: rtl/mfcc_frame_sequencer_watchdog.sv
// Per-stage watchdog: cleared on stage entry, counts while the
// stage runs, flags expiry when it sits at TIMEOUT-1.
module seq_watchdog
  import mfcc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = i_run && (r_cnt == LIM);

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Frame sequencer: window -> Hamming -> FFT -> slide, with
// per-stage watchdog, overrun counting and sticky error.
module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 clear_err_i,
  mfcc_frame_sequencer_if.master frm,
  output logic [CNT_WIDTH-1:0] frame_count_o,
  output logic [OVR_W-1:0]     overrun_count_o,
  output logic                 busy_o,
  output logic                 error_o
);

  seq_state_t r_state;
  seq_state_t w_nstate;

  logic r_ham_start;
  logic r_fft_start;
  logic r_move;
  logic r_busy;
  logic r_err;
  logic [CNT_WIDTH-1:0] r_frames;
  logic [OVR_W-1:0]     r_ovr;

  logic w_ham_go;
  logic w_fft_go;
  logic w_move_go;
  logic w_err_set;
  logic w_ovr_hit;
  logic w_wd_clr;
  logic w_wd_exp;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_wd_clr),
    .i_run    (in_stage(r_state)),
    .o_expire (w_wd_exp)
  );

  always_comb begin
    w_nstate  = r_state;
    w_ham_go  = 1'b0;
    w_fft_go  = 1'b0;
    w_move_go = 1'b0;
    w_err_set = 1'b0;
    w_ovr_hit = 1'b0;
    w_wd_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable_i && !r_err) w_nstate = S_WAIT_WIN;
      end
      S_WAIT_WIN: begin
        if (!enable_i) begin
          w_nstate = S_IDLE;
        end else if (frm.window_ready_i) begin
          w_nstate = S_HAMMING;
          w_ham_go = 1'b1;
          w_wd_clr = 1'b1;
        end
      end
      S_HAMMING: begin
        w_ovr_hit = frm.window_ready_i;
        // a done pulse coinciding with expiry still counts
        if (frm.hamming_done_i) begin
          if (frm.sink_ready_i) begin
            w_nstate = S_FFT;
            w_fft_go = 1'b1;
            w_wd_clr = 1'b1;
          end else begin
            w_nstate = S_WAIT_SINK;
          end
        end else if (w_wd_exp) begin
          w_nstate  = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_WAIT_SINK: begin
        w_ovr_hit = frm.window_ready_i;
        if (frm.sink_ready_i) begin
          w_nstate = S_FFT;
          w_fft_go = 1'b1;
          w_wd_clr = 1'b1;
        end
      end
      S_FFT: begin
        w_ovr_hit = frm.window_ready_i;
        if (frm.fft_done_i) begin
          w_nstate  = S_MOVE;
          w_move_go = 1'b1;
        end else if (w_wd_exp) begin
          w_nstate  = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_MOVE: begin
        w_ovr_hit = frm.window_ready_i;
        w_nstate  = enable_i ? S_WAIT_WIN : S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ham_start <= 1'b0;
      r_fft_start <= 1'b0;
      r_move      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_frames    <= '0;
      r_ovr       <= '0;
    end else begin
      r_state     <= w_nstate;
      r_ham_start <= w_ham_go;
      r_fft_start <= w_fft_go;
      r_move      <= w_move_go;
      r_busy      <= (w_nstate != S_IDLE);
      if (w_move_go) r_frames <= r_frames + 1'b1;
      if (clear_err_i) r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
      if (clear_err_i) r_ovr <= '0;
      else if (w_ovr_hit && (r_ovr != OVR_MAX)) r_ovr <= r_ovr + 1'b1;
    end
  end

  assign frm.hamming_start_o = r_ham_start;
  assign frm.fft_start_o     = r_fft_start;
  assign frm.start_move_o    = r_move;
  assign frame_count_o       = r_frames;
  assign overrun_count_o     = r_ovr;
  assign busy_o              = r_busy;
  assign error_o             = r_err;

endmodule
